activation_sched: RTL and testbench
===================================

# activation_sched

Round-robin scheduler that shares one Q8.8 activation datapath (sigmoid/tanh pair with a fixed registered latency) between two layer engines. It grants whole bursts of up to MAX_LEN elements to one requester at a time and forwards that requester's stream into the activation unit. It returns results tagged with requester id and a last flag. It sits between the layer MAC engines and the activation units in the SimpleGAN datapath.

## Interface
- DATA_W, 16, sample width (Q8.8)
- LEN_W, 8, burst length field width; MAX_LEN = 2^LEN_W − 1
- clk  in  1  clock
- rst_n  in  1  reset, synchronous and active-low
- req  in  2  burst request per requester; hold until matching gnt bit
- len0, len1  in  LEN_W  element count of burst, sampled at grant
- func0, func1  in  1  function select per requester (0 = sigmoid, 1 = tanh), sampled at grant
- gnt  out  2  one-hot, high for the whole granted burst (BURST + DRAIN)
- x0, x1  in  DATA_W  input samples
- x_valid  in  2  sample valid per requester
- x_ready  out  2  sample ready per requester
- act_valid_in  out  1  to activation unit
- act_x  out  DATA_W  to activation unit
- act_func  out  1  selects sigmoid/tanh result path
- act_valid_out  in  1  from activation unit
- act_y  in  DATA_W  from activation unit
- y_valid  out  1  result valid (registered)
- y_out  out  DATA_W  result
- y_id  out  1  requester owning the result
- y_last  out  1  final result of burst
- done  out  2  one-cycle pulse per requester, coincident with y_last

## Operation
- FSM: IDLE, BURST, DRAIN.
- IDLE: if any req bit is set, the scheduler grants one requester. If both are set, the requester not equal to the priority pointer `last` wins. The scheduler latches the granted requester's len/func and clears the issue and result counters.
  - len ≠ 0: the FSM moves to BURST.
  - len = 0: the FSM stays in IDLE. It pulses done for that requester in the next cycle with no y_valid, and updates `last`.
- BURST: x_ready[g] = 1 and the other bit is 0. act_valid_in = x_valid[g] & x_ready[g]; act_x = x_g; act_func = latched func. All three are combinational.
  - Each handshake increments the issue count.
  - The handshake with issue count = len−1 moves the FSM to DRAIN.
- DRAIN: x_ready = 0 and act_valid_in = 0.
- Results: act_valid_out is accepted only in BURST or DRAIN and ignored in IDLE. Each accepted result registers y_out = act_y, y_id = g, y_valid = 1, and increments the result count.
- Burst end: the result with count = len−1 also registers y_last = 1 and done[g] = 1. At that edge the FSM returns to IDLE, `last` ← g, and gnt clears.
- The requester must drop or renew req after its gnt falls. A req still high in IDLE is treated as a new burst.
- Counters are LEN_W bits wide and never wrap, because len ≤ MAX_LEN.
- act_func and act_x hold their last value outside BURST; act_valid_in stays 0.

## Timing
- Reset: state IDLE, last = 1 (requester 0 has first priority), gnt = 0, x_ready = 0, act_valid_in = 0, act_x = 0, act_func = 0, y_valid = 0, y_out = 0, y_id = 0, y_last = 0, done = 0, all counters 0.
- Reset mid-burst drops all in-flight elements. Results arriving after reset are ignored, because the FSM is in IDLE.
- Grant latency: req sampled high at edge N → gnt and x_ready high from N+1.
- With a 1-cycle activation unit, the result for the sample issued in cycle k appears on y at cycle k+2.
- The FSM works for any activation latency ≥ 1, because DRAIN counts results rather than cycles.
- Back-to-back bursts: the FSM always spends at least one IDLE cycle between bursts.
- y_valid, y_last and done are single-cycle pulses per result and have no backpressure; downstream must accept every result.

## Configuration
- ACT_SCHED_STATS_EN defined: adds outputs stat_bursts0, stat_bursts1 (16 b each) and stat_busy (32 b).
  - stat_bursts0/stat_bursts1 increment on each done pulse (zero-length bursts included) and saturate at all-ones.
  - stat_busy counts cycles in BURST or DRAIN and saturates.
  - All three clear on reset.
- ACT_SCHED_STATS_EN undefined: the ports and counters are absent; all other behaviour is identical.

## Test plan
- Single burst: req0, len0 = 4, func0 = 1, x0 = 0x0100, 0x0080, 0xFF00, 0x0000 all valid, 1-cycle tanh unit → 4 y_valid with y_id = 0, y_last and done[0] on the 4th result only, then FSM back in IDLE.
- Simultaneous req = 2'b11 after reset → requester 0 granted first, requester 1 granted in the first IDLE after done[0]. When both request again, requester 0 is granted.
- Bubbles: x_valid[1] toggling 1,0,0,1,1 with len1 = 3 → act_valid_in mirrors the handshakes, exactly 3 results, x_ready[0] stays 0 throughout.
- len0 = 0 → no act_valid_in, no y_valid, done[0] pulses the cycle after the grant, and `last` moves to 0.
- Reset at the 2nd element of a 5-element burst → all outputs take reset values next cycle, the late act_valid_out is ignored, and a new req0 is granted normally.
- With ACT_SCHED_STATS_EN: two bursts of len 3 on requester 1 → stat_bursts1 = 2, and stat_busy equals the total BURST+DRAIN cycles.

Source files
------------

// File: rtl/activation_sched_if.sv
// Handshake bundle between the layer engines, the activation scheduler and the activation unit.
interface activation_sched_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LEN_W  = 8
);
  logic [1:0]        req;
  logic [LEN_W-1:0]  len0;
  logic [LEN_W-1:0]  len1;
  logic              func0;
  logic              func1;
  logic [1:0]        gnt;
  logic [DATA_W-1:0] x0;
  logic [DATA_W-1:0] x1;
  logic [1:0]        x_valid;
  logic [1:0]        x_ready;
  logic              act_valid_in;
  logic [DATA_W-1:0] act_x;
  logic              act_func;
  logic              act_valid_out;
  logic [DATA_W-1:0] act_y;
  logic              y_valid;
  logic [DATA_W-1:0] y_out;
  logic              y_id;
  logic              y_last;
  logic [1:0]        done;

  modport slave (
    input  req, len0, len1, func0, func1, x0, x1, x_valid, act_valid_out, act_y,
    output gnt, x_ready, act_valid_in, act_x, act_func, y_valid, y_out, y_id, y_last, done
  );

  modport master (
    output req, len0, len1, func0, func1, x0, x1, x_valid, act_valid_out, act_y,
    input  gnt, x_ready, act_valid_in, act_x, act_func, y_valid, y_out, y_id, y_last, done
  );
endinterface

// File: rtl/activation_sched.sv
// Round-robin burst scheduler sharing one activation unit between two layer engines.
// Optional statistics counters enabled by defining ACT_SCHED_STATS_EN.
module activation_sched #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LEN_W  = 8
) (
  input  logic clk,
  input  logic rst_n,
`ifdef ACT_SCHED_STATS_EN
  output logic [15:0] stat_bursts0,
  output logic [15:0] stat_bursts1,
  output logic [31:0] stat_busy,
`endif
  activation_sched_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BURST = 2'd1, S_DRAIN = 2'd2} state_e;

  state_e            state_q, state_d;
  logic              g_q, g_d;
  logic              last_q, last_d;
  logic              func_q, func_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  iss_q, iss_d;
  logic [LEN_W-1:0]  res_q, res_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [DATA_W-1:0] act_x_q, act_x_d;
  logic              act_func_q, act_func_d;
  logic              y_valid_q, y_valid_d;
  logic [DATA_W-1:0] y_out_q, y_out_d;
  logic              y_id_q, y_id_d;
  logic              y_last_q, y_last_d;
  logic [1:0]        done_q, done_d;

  logic              in_burst, xv_sel, hs, res_acc, win;
  logic [DATA_W-1:0] x_sel;
  logic [LEN_W-1:0]  len_sel;
  logic [1:0]        g_onehot;

  // Stream selection for the granted requester; ties go to the one not served last.
  always_comb begin
    in_burst = (state_q == S_BURST);
    x_sel    = g_q ? bus.x1 : bus.x0;
    xv_sel   = g_q ? bus.x_valid[1] : bus.x_valid[0];
    hs       = in_burst && xv_sel;
    res_acc  = bus.act_valid_out && (state_q != S_IDLE);
    win      = (bus.req == 2'b11) ? ~last_q : bus.req[1];
    len_sel  = win ? bus.len1 : bus.len0;
    g_onehot = g_q ? 2'b10 : 2'b01;
  end

  assign bus.x_ready      = in_burst ? g_onehot : 2'b00;
  assign bus.act_valid_in = hs;
  assign bus.act_x        = in_burst ? x_sel  : act_x_q;
  assign bus.act_func     = in_burst ? func_q : act_func_q;
  assign bus.gnt          = gnt_q;
  assign bus.y_valid      = y_valid_q;
  assign bus.y_out        = y_out_q;
  assign bus.y_id         = y_id_q;
  assign bus.y_last       = y_last_q;
  assign bus.done         = done_q;

  always_comb begin
    state_d    = state_q;
    g_d        = g_q;
    last_d     = last_q;
    func_d     = func_q;
    len_d      = len_q;
    iss_d      = iss_q;
    res_d      = res_q;
    gnt_d      = gnt_q;
    y_valid_d  = 1'b0;
    y_out_d    = y_out_q;
    y_id_d     = y_id_q;
    y_last_d   = 1'b0;
    done_d     = 2'b00;
    act_x_d    = in_burst ? x_sel  : act_x_q;
    act_func_d = in_burst ? func_q : act_func_q;

    case (state_q)
      S_IDLE: begin
        gnt_d = 2'b00;
        if (|bus.req) begin
          g_d    = win;
          len_d  = len_sel;
          func_d = win ? bus.func1 : bus.func0;
          iss_d  = '0;
          res_d  = '0;
          gnt_d  = win ? 2'b10 : 2'b01;
          if (len_sel == '0) begin
            done_d = win ? 2'b10 : 2'b01;
            last_d = win;
          end else begin
            state_d = S_BURST;
          end
        end
      end
      S_BURST: begin
        if (hs) begin
          iss_d = iss_q + LEN_W'(1);
          if (iss_q == len_q - LEN_W'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: state_d = S_DRAIN;
      default: state_d = S_IDLE;
    endcase

    // Burst completes on the final result, not on a cycle count, so any unit latency works.
    if (res_acc) begin
      y_valid_d = 1'b1;
      y_out_d   = bus.act_y;
      y_id_d    = g_q;
      res_d     = res_q + LEN_W'(1);
      if (res_q == len_q - LEN_W'(1)) begin
        y_last_d = 1'b1;
        done_d   = g_onehot;
        state_d  = S_IDLE;
        last_d   = g_q;
        gnt_d    = 2'b00;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      g_q        <= 1'b0;
      last_q     <= 1'b1;
      func_q     <= 1'b0;
      len_q      <= '0;
      iss_q      <= '0;
      res_q      <= '0;
      gnt_q      <= 2'b00;
      act_x_q    <= '0;
      act_func_q <= 1'b0;
      y_valid_q  <= 1'b0;
      y_out_q    <= '0;
      y_id_q     <= 1'b0;
      y_last_q   <= 1'b0;
      done_q     <= 2'b00;
    end else begin
      state_q    <= state_d;
      g_q        <= g_d;
      last_q     <= last_d;
      func_q     <= func_d;
      len_q      <= len_d;
      iss_q      <= iss_d;
      res_q      <= res_d;
      gnt_q      <= gnt_d;
      act_x_q    <= act_x_d;
      act_func_q <= act_func_d;
      y_valid_q  <= y_valid_d;
      y_out_q    <= y_out_d;
      y_id_q     <= y_id_d;
      y_last_q   <= y_last_d;
      done_q     <= done_d;
    end
  end

`ifdef ACT_SCHED_STATS_EN
  localparam int unsigned STAT_BW = 16;
  localparam int unsigned STAT_TW = 32;

  logic [STAT_BW-1:0] sb0_q, sb0_d;
  logic [STAT_BW-1:0] sb1_q, sb1_d;
  logic [STAT_TW-1:0] busy_q, busy_d;

  // Saturating burst and busy-cycle counters.
  always_comb begin
    sb0_d  = sb0_q;
    sb1_d  = sb1_q;
    busy_d = busy_q;
    if (done_d[0] && (sb0_q != '1)) sb0_d = sb0_q + STAT_BW'(1);
    if (done_d[1] && (sb1_q != '1)) sb1_d = sb1_q + STAT_BW'(1);
    if ((state_q != S_IDLE) && (busy_q != '1)) busy_d = busy_q + STAT_TW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sb0_q  <= '0;
      sb1_q  <= '0;
      busy_q <= '0;
    end else begin
      sb0_q  <= sb0_d;
      sb1_q  <= sb1_d;
      busy_q <= busy_d;
    end
  end

  assign stat_bursts0 = sb0_q;
  assign stat_bursts1 = sb1_q;
  assign stat_busy    = busy_q;
`endif
endmodule

// File: tb/tb_activation_sched.sv
// Randomized bench for activation_sched: two requester agents, a delay-line activation unit and a result scoreboard.
module tb_activation_sched;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned LEN_W  = 8;

  typedef struct packed {
    logic [15:0] y;
    logic        id;
    logic        last;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int lat      = 1;

  logic req0 = 0, req1 = 0, func0_v = 0, func1_v = 0, xv0 = 0, xv1 = 0;
  logic [LEN_W-1:0]  len0_v = '0, len1_v = '0;
  logic [DATA_W-1:0] x0_v = '0, x1_v = '0;
  logic [3:0]        vp = 4'b0;
  logic [DATA_W-1:0] yp [4];
  logic [4:0]        pat = 5'b11001;

  res_t        obs_q[$];
  res_t        exp_q[$];
  int          hs_cyc_q[$];
  int          y_cyc_q[$];
  logic [15:0] fixed_q[$];
  int hs_cnt = 0, xr0_cnt = 0, done0_cnt = 0, done1_cnt = 0;
  int avi_bad = 0, xr_bad = 0, done_bad = 0;

  activation_sched_if #(.DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

`ifdef ACT_SCHED_STATS_EN
  logic [15:0] sb0, sb1;
  logic [31:0] sbusy;
`endif

  activation_sched #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef ACT_SCHED_STATS_EN
    .stat_bursts0(sb0),
    .stat_bursts1(sb1),
    .stat_busy(sbusy),
`endif
    .bus(bus)
  );

  assign bus.req     = {req1, req0};
  assign bus.len0    = len0_v;
  assign bus.len1    = len1_v;
  assign bus.func0   = func0_v;
  assign bus.func1   = func1_v;
  assign bus.x0      = x0_v;
  assign bus.x1      = x1_v;
  assign bus.x_valid = {xv1, xv0};

  // Stand-in sigmoid/tanh: clamped linear approximations in Q8.8.
  function automatic logic [15:0] act_ref(input logic [15:0] x, input logic f);
    int s;
    s = int'($signed(x));
    if (f) begin
      if (s > 256) s = 256;
      else if (s < -256) s = -256;
    end else begin
      s = (s >>> 2) + 128;
      if (s < 0) s = 0;
      else if (s > 256) s = 256;
    end
    return 16'(s);
  endfunction

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    vp    <= {vp[2:0], bus.act_valid_in};
    yp[0] <= act_ref(bus.act_x, bus.act_func);
    for (int i = 1; i < 4; i++) yp[i] <= yp[i-1];
  end

  always_comb begin
    bus.act_valid_out = vp[lat-1];
    bus.act_y         = yp[lat-1];
  end

  // Observation of every cycle, after the negedge drive has settled.
  always begin
    res_t r;
    @(negedge clk);
    #1;
    if (bus.y_valid) begin
      r.y = bus.y_out; r.id = bus.y_id; r.last = bus.y_last;
      obs_q.push_back(r);
      y_cyc_q.push_back(cyc);
    end
    if (bus.act_valid_in) begin
      hs_cnt++;
      hs_cyc_q.push_back(cyc);
    end
    if (bus.x_ready[0]) xr0_cnt++;
    if (bus.done[0]) done0_cnt++;
    if (bus.done[1]) done1_cnt++;
    if (bus.act_valid_in !== |(bus.x_ready & bus.x_valid)) avi_bad++;
    if ((bus.x_ready & ~bus.gnt) != 2'b00) xr_bad++;
    if (bus.y_valid && (bus.done !== (bus.y_last ? (bus.y_id ? 2'b10 : 2'b01) : 2'b00))) done_bad++;
    if (!bus.y_valid && bus.y_last) done_bad++;
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; req0 = 0; req1 = 0; xv0 = 0; xv1 = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic agent(input int id, input int dly, input int len, input logic fn, input int vmode,
                       output int r_c, output int g_c, output int d_c);
    int guard, sent, p;
    logic v;
    logic [15:0] d;
    res_t e;
    g_c = -1; d_c = -1;
    repeat (dly) @(negedge clk);
    @(negedge clk);
    if (id == 0) begin req0 = 1; len0_v = LEN_W'(len); func0_v = fn; end
    else         begin req1 = 1; len1_v = LEN_W'(len); func1_v = fn; end
    r_c = cyc;
    guard = 0;
    do begin @(posedge clk); #1; guard++; end while (!bus.gnt[id] && guard < 400);
    if (id == 0) req0 = 0; else req1 = 0;
    n_checks++;
    if (!bus.gnt[id]) begin
      n_fail++;
      $display("FAIL agent%0d_gnt: gnt=%b after %0d cycles, required bit %0d set", id, bus.gnt, guard, id);
      return;
    end
    g_c = cyc;
    sent = 0; p = 0; guard = 0;
    while (sent < len && guard < 1000) begin
      @(negedge clk);
      case (vmode)
        0:       v = 1'b1;
        1:       v = 1'($urandom_range(0, 1));
        default: v = pat[p % 5];
      endcase
      p++; guard++;
      d = (fixed_q.size() != 0) ? fixed_q[0] : 16'($urandom);
      if (id == 0) begin xv0 = v; x0_v = d; end else begin xv1 = v; x1_v = d; end
      if (v && bus.x_ready[id]) begin
        if (fixed_q.size() != 0) void'(fixed_q.pop_front());
        e.y = act_ref(d, fn); e.id = 1'(id); e.last = (sent == len - 1);
        exp_q.push_back(e);
        sent++;
      end
    end
    if (len > 0) begin
      @(posedge clk); #1;
      if (id == 0) xv0 = 0; else xv1 = 0;
    end
    guard = 0;
    while (!bus.done[id] && guard < 1000) begin @(negedge clk); guard++; end
    n_checks++;
    if (!bus.done[id]) begin
      n_fail++;
      $display("FAIL agent%0d_done: done=%b after %0d cycles, required bit %0d set", id, bus.done, guard, id);
      return;
    end
    d_c = cyc;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++;
    if ({bus.gnt, bus.x_ready, bus.act_valid_in, bus.act_x, bus.act_func, bus.y_valid, bus.y_out,
         bus.y_id, bus.y_last, bus.done} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: gnt=%b x_ready=%b avi=%b act_x=%h func=%b yv=%b y=%h id=%b last=%b done=%b, required all 0",
               bus.gnt, bus.x_ready, bus.act_valid_in, bus.act_x, bus.act_func, bus.y_valid, bus.y_out,
               bus.y_id, bus.y_last, bus.done);
    end
  endtask

  task automatic test_single_burst();
    int r, g, d, ob, hb, yb, d0b;
    logic [15:0] want [4];
    want[0] = 16'h0100; want[1] = 16'h0080; want[2] = 16'hFF00; want[3] = 16'h0000;
    lat = 1;
    for (int i = 0; i < 4; i++) fixed_q.push_back(want[i]);
    ob = obs_q.size(); hb = hs_cyc_q.size(); yb = y_cyc_q.size(); d0b = done0_cnt;
    agent(0, 0, 4, 1'b1, 0, r, g, d);
    n_checks++;
    if (g - r != 1) begin n_fail++; $display("FAIL single_gnt_latency: got %0d cycles, required 1", g - r); end
    n_checks++;
    if ((bus.gnt !== 2'b00) || (bus.x_ready !== 2'b00)) begin
      n_fail++; $display("FAIL single_idle_after: gnt=%b x_ready=%b, required 00 00", bus.gnt, bus.x_ready);
    end
    @(negedge clk); #2;
    n_checks++;
    if (obs_q.size() - ob != 4) begin
      n_fail++; $display("FAIL single_count: got %0d results, required 4", obs_q.size() - ob);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (obs_q[ob+i] !== {want[i], 1'b0, 1'(i == 3)}) begin
          n_fail++;
          $display("FAIL single_result%0d: y=%h id=%b last=%b, required y=%h id=0 last=%b",
                   i, obs_q[ob+i].y, obs_q[ob+i].id, obs_q[ob+i].last, want[i], i == 3);
        end
      end
      n_checks++;
      if (y_cyc_q[yb] - hs_cyc_q[hb] != 2) begin
        n_fail++; $display("FAIL single_result_latency: got %0d, required 2", y_cyc_q[yb] - hs_cyc_q[hb]);
      end
    end
    n_checks++;
    if (done0_cnt - d0b != 1) begin n_fail++; $display("FAIL single_done_count: got %0d, required 1", done0_cnt - d0b); end
  endtask

  task automatic test_arbitration();
    int r0, g0, d0, r1, g1, d1, ob, eb;
    lat = 2;
    do_reset();
    for (int round = 0; round < 2; round++) begin
      ob = obs_q.size(); eb = exp_q.size();
      fork
        agent(0, 0, 3, 1'b1, 0, r0, g0, d0);
        agent(1, 0, 2, 1'b0, 0, r1, g1, d1);
      join
      @(negedge clk); #2;
      n_checks++;
      if (!(g0 < g1)) begin n_fail++; $display("FAIL arb_order%0d: gnt0 at %0d gnt1 at %0d, required gnt0 first", round, g0, g1); end
      n_checks++;
      if (g1 != d0 + 1) begin n_fail++; $display("FAIL arb_regrant%0d: gnt1 at %0d, required %0d", round, g1, d0 + 1); end
      n_checks++;
      if ((obs_q.size() - ob != 5) || (exp_q.size() - eb != 5)) begin
        n_fail++; $display("FAIL arb_count%0d: got %0d results, required 5", round, obs_q.size() - ob);
      end else begin
        for (int i = 0; i < 5; i++) begin
          n_checks++;
          if (obs_q[ob+i] !== exp_q[eb+i]) begin
            n_fail++; $display("FAIL arb_result%0d_%0d: got %h, required %h", round, i, obs_q[ob+i], exp_q[eb+i]);
          end
        end
      end
    end
  endtask

  task automatic test_bubbles();
    int r, g, d, ob, eb, hb, xb, ab;
    lat = 1;
    ob = obs_q.size(); eb = exp_q.size(); hb = hs_cnt; xb = xr0_cnt; ab = avi_bad;
    agent(1, 0, 3, 1'b0, 2, r, g, d);
    @(negedge clk); #2;
    n_checks++;
    if (hs_cnt - hb != 3) begin n_fail++; $display("FAIL bubble_issues: got %0d, required 3", hs_cnt - hb); end
    n_checks++;
    if (xr0_cnt != xb) begin n_fail++; $display("FAIL bubble_xready0: got %0d cycles high, required 0", xr0_cnt - xb); end
    n_checks++;
    if (avi_bad != ab) begin n_fail++; $display("FAIL bubble_avi_mirror: got %0d bad cycles, required 0", avi_bad - ab); end
    n_checks++;
    if (obs_q.size() - ob != 3) begin
      n_fail++; $display("FAIL bubble_count: got %0d results, required 3", obs_q.size() - ob);
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (obs_q[ob+i] !== exp_q[eb+i]) begin
          n_fail++; $display("FAIL bubble_result%0d: got %h, required %h", i, obs_q[ob+i], exp_q[eb+i]);
        end
      end
    end
  endtask

  task automatic test_zero_len();
    int r, g, d, r0, g0, d0, r1, g1, d1, ob, hb, d0b, d1b;
    ob = obs_q.size(); hb = hs_cnt; d0b = done0_cnt; d1b = done1_cnt;
    agent(0, 0, 0, 1'b0, 0, r, g, d);
    @(negedge clk); #2;
    n_checks++;
    if (d - g != 0) begin n_fail++; $display("FAIL zero_done_timing: done %0d cycles after gnt, required 0", d - g); end
    n_checks++;
    if ((hs_cnt != hb) || (obs_q.size() != ob)) begin
      n_fail++; $display("FAIL zero_no_traffic: issues=%0d results=%0d, required 0 0", hs_cnt - hb, obs_q.size() - ob);
    end
    n_checks++;
    if ((done0_cnt - d0b != 1) || (done1_cnt != d1b)) begin
      n_fail++; $display("FAIL zero_done_pulse: done0=%0d done1=%0d, required 1 0", done0_cnt - d0b, done1_cnt - d1b);
    end
    fork
      agent(0, 0, 1, 1'b0, 0, r0, g0, d0);
      agent(1, 0, 1, 1'b1, 0, r1, g1, d1);
    join
    n_checks++;
    if (!(g1 < g0)) begin n_fail++; $display("FAIL zero_last_moves: gnt1 at %0d gnt0 at %0d, required gnt1 first", g1, g0); end
  endtask

  task automatic test_reset_mid();
    int n, guard, r, g, d, ob, eb;
    lat = 1;
    @(negedge clk);
    req0 = 1; len0_v = LEN_W'(5); func0_v = 1'b0;
    guard = 0;
    do begin @(posedge clk); #1; guard++; end while (!bus.gnt[0] && guard < 100);
    req0 = 0;
    n = 0; guard = 0;
    while (n < 2 && guard < 100) begin
      @(negedge clk);
      guard++;
      xv0 = 1; x0_v = 16'($urandom);
      if (bus.x_ready[0]) n++;
      if (n == 2) rst_n = 0;
    end
    @(negedge clk);
    rst_n = 1; xv0 = 0;
    #1;
    n_checks++;
    if ({bus.gnt, bus.x_ready, bus.act_valid_in, bus.act_x, bus.act_func, bus.y_valid, bus.y_out,
         bus.y_id, bus.y_last, bus.done} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: gnt=%b x_ready=%b avi=%b act_x=%h func=%b yv=%b y=%h id=%b last=%b done=%b, required all 0",
               bus.gnt, bus.x_ready, bus.act_valid_in, bus.act_x, bus.act_func, bus.y_valid, bus.y_out,
               bus.y_id, bus.y_last, bus.done);
    end
    @(negedge clk); #1;
    n_checks++;
    if ((bus.y_valid !== 1'b0) || (bus.gnt !== 2'b00)) begin
      n_fail++; $display("FAIL midreset_late_result: y_valid=%b gnt=%b, required 0 00", bus.y_valid, bus.gnt);
    end
    ob = obs_q.size(); eb = exp_q.size();
    agent(0, 0, 2, 1'b1, 0, r, g, d);
    @(negedge clk); #2;
    n_checks++;
    if (g - r != 1) begin n_fail++; $display("FAIL midreset_regrant: latency %0d, required 1", g - r); end
    n_checks++;
    if ((obs_q.size() - ob != 2) || (obs_q[ob] !== exp_q[eb]) || (obs_q[ob+1] !== exp_q[eb+1])) begin
      n_fail++; $display("FAIL midreset_results: got %0d results, required 2 matching", obs_q.size() - ob);
    end
  endtask

  task automatic test_random();
    int r0, g0, d0, r1, g1, d1, ob, eb, l0, l1, w0, w1, m0, m1;
    logic f0, f1;
    for (int it = 0; it < 8; it++) begin
      lat = $urandom_range(1, 4);
      l0 = $urandom_range(0, 10); l1 = $urandom_range(0, 10);
      w0 = $urandom_range(0, 3);  w1 = $urandom_range(0, 3);
      m0 = $urandom_range(0, 2);  m1 = $urandom_range(0, 2);
      f0 = 1'($urandom);          f1 = 1'($urandom);
      ob = obs_q.size(); eb = exp_q.size();
      fork
        agent(0, w0, l0, f0, m0, r0, g0, d0);
        agent(1, w1, l1, f1, m1, r1, g1, d1);
      join
      repeat (2) @(negedge clk);
      #2;
      n_checks++;
      if (obs_q.size() - ob != l0 + l1) begin
        n_fail++; $display("FAIL rand%0d_count: got %0d results, required %0d", it, obs_q.size() - ob, l0 + l1);
      end else begin
        for (int i = 0; i < l0 + l1; i++) begin
          n_checks++;
          if (obs_q[ob+i] !== exp_q[eb+i]) begin
            n_fail++; $display("FAIL rand%0d_result%0d: got %h, required %h", it, i, obs_q[ob+i], exp_q[eb+i]);
          end
        end
      end
    end
    n_checks++;
    if ((avi_bad != 0) || (xr_bad != 0) || (done_bad != 0)) begin
      n_fail++; $display("FAIL protocol: avi_bad=%0d xr_bad=%0d done_bad=%0d, required 0 0 0", avi_bad, xr_bad, done_bad);
    end
  endtask

`ifdef ACT_SCHED_STATS_EN
  task automatic test_stats();
    int r, g, d, busy;
    lat = 2;
    do_reset();
    busy = 0;
    agent(1, 0, 3, 1'b0, 1, r, g, d);
    busy += d - g;
    agent(1, 1, 3, 1'b1, 1, r, g, d);
    busy += d - g;
    n_checks++;
    if ((sb1 !== 16'd2) || (sb0 !== 16'd0)) begin
      n_fail++; $display("FAIL stats_bursts: b0=%0d b1=%0d, required 0 2", sb0, sb1);
    end
    n_checks++;
    if (sbusy !== 32'(busy)) begin n_fail++; $display("FAIL stats_busy: got %0d, required %0d", sbusy, busy); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_burst();
    test_arbitration();
    test_bubbles();
    test_zero_len();
    test_reset_mid();
    test_random();
`ifdef ACT_SCHED_STATS_EN
    test_stats();
`endif
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
